riscv_compressed_encoder: RTL and testbench
===========================================

Name: riscv_compressed_encoder

Overview:
- Streaming RV32 to RVC compressor: the inverse of the compressed decoder.
- Accepts one 32-bit RV32I instruction per handshake and emits a compressed halfword when an RVC equivalent exists; otherwise the instruction passes through at full width.
- Packs the result into a contiguous 32-bit little-endian halfword stream for the boot/loader path or instruction-memory writer.
- One halfword holding register plus one output register; instruction immediates are never relocated.

Parameters:
- NOP_HALF, 16'h0001, padding halfword used on flush (c.nop).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid_i  input  1  input instruction valid
- in_ready_o  output  1  input accepted when in_valid_i && in_ready_o
- in_instr_i  input  32  RV32 instruction
- flush_i  input  1  emit pending halfword padded with NOP_HALF
- out_valid_o  output  1  out_data_o valid
- out_ready_i  input  1  downstream accepts word
- out_data_o  output  32  packed word, lower halfword first in program order
- pending_o  output  1  a halfword is held (state HALF)
- compressed_o  output  1  combinational: in_instr_i is compressible

Behaviour:
- Reset values: out_valid_o=0, out_data_o=0, pending_o=0, holding reg=0, state EMPTY.
- in_ready_o = !out_valid_o || out_ready_i. Output register clears valid on out_ready_i when no new word is loaded. Output data is stable while out_valid_o && !out_ready_i.
- Encoding is combinational. Input with in_instr_i[1:0]!=2'b11 is treated as uncompressible. Rules are checked in the priority order below; the first match wins:
  - addi x0,x0,0 -> 0x0001.
  - addi rd,x0,imm, rd!=0, imm in [-32,31] -> c.li.
  - addi rd,rd,imm, rd!=0, imm!=0, in [-32,31] -> c.addi.
  - addi x2,x2,imm, imm!=0, imm%16==0, in [-512,496] -> c.addi16sp.
  - addi rd',x2,imm, imm%4==0, in [4,1020] -> c.addi4spn.
  - lui rd,imm, rd not in {0,2}, imm[19:5] all equal to imm[5], imm!=0 -> c.lui.
  - lw/sw with rd'/rs2' and rs1', off%4==0, in [0,124] -> c.lw/c.sw.
  - lw rd!=0 / sw, with rs1=x2, off%4==0, in [0,252] -> c.lwsp/c.swsp.
  - slli rd,rd,sh, rd!=0, 0<sh<32 -> c.slli. srli/srai rd',rd',sh, 0<sh<32 -> c.srli/c.srai.
  - andi rd',rd',imm, imm in [-32,31] -> c.andi.
  - add rd,x0,rs2, rd!=0, rs2!=0 -> c.mv. add rd,rd,rs2, rd!=0, rs2!=0 -> c.add.
  - sub/xor/or/and rd',rd',rs2' -> C1 arithmetic forms.
  - ebreak (0x00100073) -> 0x9002.
  - rd'/rs1'/rs2' means x8..x15.
- State machine (advances only on an input fire):
  - EMPTY + compressed c: hold=c, go to HALF, no output.
  - EMPTY + 32-bit w: out=w, stay EMPTY.
  - HALF + compressed c: out={c,hold}, go to EMPTY.
  - HALF + 32-bit w: out={w[15:0],hold}, hold=w[31:16], stay HALF.
- Flush is sampled only when in_valid_i=0 and in_ready_o=1:
  - HALF: out={NOP_HALF,hold}, go to EMPTY.
  - EMPTY: no-op.
  - If flush_i and in_valid_i are both high, the instruction is consumed and flush is ignored that cycle. The requester holds flush_i until pending_o=0.
- Latency: one cycle from fire to out_valid_o for any word-producing event.
- rst during any state drops the held halfword and any unaccepted output word.

Optional Feature:
- Macro: RVC_ENC_CTRL_EN.
- Defined: control transfers are also compressed.
  - jalr x0,rs1,0 with rs1!=0 -> c.jr.
  - jalr x1,rs1,0 with rs1!=0 -> c.jalr.
  - jal x0/x1 with off in [-2048,2046] -> c.j/c.jal.
  - beq/bne rs1',x0 with off in [-256,254] -> c.beqz/c.bnez.
  - Offsets are copied unchanged.
- Undefined: all control transfers pass through as 32-bit and compressed_o=0 for them.

Test Plan:
- EMPTY: send 0x00140413 (addi x8,x8,1), then 0x00500513 (li x10,5) -> one word 0x45150405, one cycle after the second fire; pending_o toggles 1 then 0.
- EMPTY: send 0x003100B3 (add x1,x2,x3, rd!=rs1) -> out 0x003100B3, compressed_o=0, state stays EMPTY.
- Send 0x00140413, then 0x003100B3 -> out 0x00B30405, pending_o=1. Then pulse flush_i -> out 0x00010031, pending_o=0.
- Hold out_ready_i=0 with out_valid_o=1 -> in_ready_o=0 and out_data_o stable for 5 cycles. Raise out_ready_i -> next input accepted the same cycle.
- Assert rst while in HALF with out_valid_o=1 -> next cycle all outputs 0. A following 0x00140413 then flush -> 0x00010405.
- Send 0x00008067 (jr x1) -> out 0x8082 halfword with RVC_ENC_CTRL_EN defined; 32-bit passthrough 0x00008067 without it.

Source files
------------

// File: rtl/riscv_compressed_encoder.sv
// riscv_compressed_encoder: RV32I to RVC compressor and halfword packer.
// Define RVC_ENC_CTRL_EN to also compress jumps and branches.
module riscv_compressed_encoder #(
  parameter logic [15:0] NOP_HALF = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        pending_o,
  output logic        compressed_o
);

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef enum logic {
    EMPTY,
    HALF
  } state_t;

  state_t      state;
  logic [15:0] hold;

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic [19:0] imm_u;

  logic rd_p;
  logic rs1_p;
  logic rs2_p;
  logic rd_z;
  logic rs1_z;
  logic rs2_z;
  logic same;
  logic i_fit6;
  logic u_fit6;
  logic i_fit10;

  logic is_addi;
  logic is_lw;
  logic is_sw;
  logic is_rr;

  logic m_nop;
  logic m_li;
  logic m_addi;
  logic m_a16sp;
  logic m_a4spn;
  logic m_lui;
  logic m_lw;
  logic m_sw;
  logic m_lwsp;
  logic m_swsp;
  logic m_slli;
  logic m_srli;
  logic m_srai;
  logic m_andi;
  logic m_mv;
  logic m_add;
  logic m_arith;
  logic m_ebrk;

  logic [1:0]  arith_sel;
  logic [15:0] c_half;
  logic        c_ok;

  logic fire;
  logic flush_go;

  assign ins   = in_instr_i;
  assign opc   = ins[6:0];
  assign rd    = ins[11:7];
  assign f3    = ins[14:12];
  assign rs1   = ins[19:15];
  assign rs2   = ins[24:20];
  assign f7    = ins[31:25];
  assign imm_i = ins[31:20];
  assign imm_s = {ins[31:25], ins[11:7]};
  assign imm_u = ins[31:12];

  // rd'/rs1'/rs2' cover x8..x15
  assign rd_p  = rd[4:3] == 2'b01;
  assign rs1_p = rs1[4:3] == 2'b01;
  assign rs2_p = rs2[4:3] == 2'b01;
  assign rd_z  = rd == 5'd0;
  assign rs1_z = rs1 == 5'd0;
  assign rs2_z = rs2 == 5'd0;
  assign same  = rs1 == rd;

  assign i_fit6  = (imm_i[11:5] == '0)
                || (imm_i[11:5] == '1);
  assign u_fit6  = (imm_u[19:5] == '0)
                || (imm_u[19:5] == '1);
  assign i_fit10 = (imm_i[11:9] == '0)
                || (imm_i[11:9] == '1);

  assign is_addi = opc == OP_IMM
                && f3 == 3'b000;
  assign is_lw   = opc == OP_LOAD
                && f3 == 3'b010;
  assign is_sw   = opc == OP_STORE
                && f3 == 3'b010;
  assign is_rr   = opc == OP_REG;

  assign m_nop   = is_addi && rd_z
                && rs1_z && imm_i == '0;
  assign m_li    = is_addi && !rd_z
                && rs1_z && i_fit6;
  assign m_addi  = is_addi && !rd_z && same
                && imm_i != '0 && i_fit6;
  assign m_a16sp = is_addi && rd == 5'd2
                && rs1 == 5'd2 && imm_i != '0
                && imm_i[3:0] == '0 && i_fit10;
  assign m_a4spn = is_addi && rd_p
                && rs1 == 5'd2 && imm_i != '0
                && imm_i[1:0] == '0
                && imm_i[11:10] == '0;
  assign m_lui   = opc == OP_LUI && !rd_z
                && rd != 5'd2 && imm_u != '0
                && u_fit6;
  assign m_lw    = is_lw && rd_p && rs1_p
                && imm_i[1:0] == '0
                && imm_i[11:7] == '0;
  assign m_sw    = is_sw && rs2_p && rs1_p
                && imm_s[1:0] == '0
                && imm_s[11:7] == '0;
  assign m_lwsp  = is_lw && !rd_z
                && rs1 == 5'd2
                && imm_i[1:0] == '0
                && imm_i[11:8] == '0;
  assign m_swsp  = is_sw && rs1 == 5'd2
                && imm_s[1:0] == '0
                && imm_s[11:8] == '0;
  assign m_slli  = opc == OP_IMM
                && f3 == 3'b001 && f7 == '0
                && !rd_z && same && !rs2_z;
  assign m_srli  = opc == OP_IMM
                && f3 == 3'b101 && f7 == '0
                && rd_p && same && !rs2_z;
  assign m_srai  = opc == OP_IMM
                && f3 == 3'b101
                && f7 == 7'b0100000
                && rd_p && same && !rs2_z;
  assign m_andi  = opc == OP_IMM
                && f3 == 3'b111
                && rd_p && same && i_fit6;
  assign m_mv    = is_rr && f3 == 3'b000
                && f7 == '0 && !rd_z
                && rs1_z && !rs2_z;
  assign m_add   = is_rr && f3 == 3'b000
                && f7 == '0 && !rd_z
                && same && !rs2_z;
  assign m_ebrk  = ins == 32'h0010_0073;

  always_comb begin
    arith_sel = 2'b00;
    m_arith   = 1'b0;
    if (is_rr && rd_p && same && rs2_p) begin
      unique case (1'b1)
        f7 == 7'b0100000 && f3 == 3'b000: begin
          arith_sel = 2'b00;
          m_arith   = 1'b1;
        end
        f7 == '0 && f3 == 3'b100: begin
          arith_sel = 2'b01;
          m_arith   = 1'b1;
        end
        f7 == '0 && f3 == 3'b110: begin
          arith_sel = 2'b10;
          m_arith   = 1'b1;
        end
        f7 == '0 && f3 == 3'b111: begin
          arith_sel = 2'b11;
          m_arith   = 1'b1;
        end
        default: m_arith = 1'b0;
      endcase
    end
  end

`ifdef RVC_ENC_CTRL_EN
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  logic [20:1] off_j;
  logic [12:1] off_b;
  logic        j_fit;
  logic        b_fit;
  logic        m_jr;
  logic        m_jalr;
  logic        m_j;
  logic        m_jal;
  logic        m_beqz;
  logic        m_bnez;

  assign off_j = {ins[31], ins[19:12],
                  ins[20], ins[30:21]};
  assign off_b = {ins[31], ins[7],
                  ins[30:25], ins[11:8]};
  assign j_fit = (off_j[20:11] == '0)
              || (off_j[20:11] == '1);
  assign b_fit = (off_b[12:8] == '0)
              || (off_b[12:8] == '1);

  assign m_jr   = opc == OP_JALR
               && f3 == 3'b000 && imm_i == '0
               && !rs1_z && rd == 5'd0;
  assign m_jalr = opc == OP_JALR
               && f3 == 3'b000 && imm_i == '0
               && !rs1_z && rd == 5'd1;
  assign m_j    = opc == OP_JAL
               && rd == 5'd0 && j_fit;
  assign m_jal  = opc == OP_JAL
               && rd == 5'd1 && j_fit;
  assign m_beqz = opc == OP_BR
               && f3 == 3'b000 && rs2_z
               && rs1_p && b_fit;
  assign m_bnez = opc == OP_BR
               && f3 == 3'b001 && rs2_z
               && rs1_p && b_fit;
`endif

  // First matching rule wins; several rules overlap.
  always_comb begin
    c_half = 16'h0000;
    c_ok   = 1'b1;
    priority case (1'b1)
      m_nop:   c_half = 16'h0001;
      m_li:    c_half = {3'b010, imm_i[5], rd,
                         imm_i[4:0], 2'b01};
      m_addi:  c_half = {3'b000, imm_i[5], rd,
                         imm_i[4:0], 2'b01};
      m_a16sp: c_half = {3'b011, imm_i[9], 5'd2,
                         imm_i[4], imm_i[6],
                         imm_i[8:7], imm_i[5],
                         2'b01};
      m_a4spn: c_half = {3'b000, imm_i[5:4],
                         imm_i[9:6], imm_i[2],
                         imm_i[3], rd[2:0], 2'b00};
      m_lui:   c_half = {3'b011, imm_u[5], rd,
                         imm_u[4:0], 2'b01};
      m_lw:    c_half = {3'b010, imm_i[5:3],
                         rs1[2:0], imm_i[2],
                         imm_i[6], rd[2:0], 2'b00};
      m_sw:    c_half = {3'b110, imm_s[5:3],
                         rs1[2:0], imm_s[2],
                         imm_s[6], rs2[2:0], 2'b00};
      m_lwsp:  c_half = {3'b010, imm_i[5], rd,
                         imm_i[4:2], imm_i[7:6],
                         2'b10};
      m_swsp:  c_half = {3'b110, imm_s[5:2],
                         imm_s[7:6], rs2, 2'b10};
      m_slli:  c_half = {3'b000, 1'b0, rd,
                         rs2, 2'b10};
      m_srli:  c_half = {3'b100, 1'b0, 2'b00,
                         rd[2:0], rs2, 2'b01};
      m_srai:  c_half = {3'b100, 1'b0, 2'b01,
                         rd[2:0], rs2, 2'b01};
      m_andi:  c_half = {3'b100, imm_i[5], 2'b10,
                         rd[2:0], imm_i[4:0],
                         2'b01};
      m_mv:    c_half = {4'b1000, rd, rs2, 2'b10};
      m_add:   c_half = {4'b1001, rd, rs2, 2'b10};
      m_arith: c_half = {6'b100011, rd[2:0],
                         arith_sel, rs2[2:0],
                         2'b01};
      m_ebrk:  c_half = 16'h9002;
`ifdef RVC_ENC_CTRL_EN
      m_jr:    c_half = {4'b1000, rs1, 5'd0, 2'b10};
      m_jalr:  c_half = {4'b1001, rs1, 5'd0, 2'b10};
      m_j:     c_half = {3'b101, off_j[11],
                         off_j[4], off_j[9:8],
                         off_j[10], off_j[6],
                         off_j[7], off_j[3:1],
                         off_j[5], 2'b01};
      m_jal:   c_half = {3'b001, off_j[11],
                         off_j[4], off_j[9:8],
                         off_j[10], off_j[6],
                         off_j[7], off_j[3:1],
                         off_j[5], 2'b01};
      m_beqz:  c_half = {3'b110, off_b[8],
                         off_b[4:3], rs1[2:0],
                         off_b[7:6], off_b[2:1],
                         off_b[5], 2'b01};
      m_bnez:  c_half = {3'b111, off_b[8],
                         off_b[4:3], rs1[2:0],
                         off_b[7:6], off_b[2:1],
                         off_b[5], 2'b01};
`endif
      default: c_ok = 1'b0;
    endcase
  end

  assign compressed_o = c_ok;
  assign in_ready_o   = !out_valid_o || out_ready_i;
  assign fire         = in_valid_i && in_ready_o;
  assign flush_go     = flush_i && !in_valid_i
                     && in_ready_o && state == HALF;
  assign pending_o    = state == HALF;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      hold        <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else begin
      if (out_ready_i) out_valid_o <= 1'b0;
      if (fire) begin
        unique case (state)
          EMPTY: begin
            if (c_ok) begin
              hold  <= c_half;
              state <= HALF;
            end else begin
              out_data_o  <= ins;
              out_valid_o <= 1'b1;
            end
          end
          HALF: begin
            out_valid_o <= 1'b1;
            if (c_ok) begin
              out_data_o <= {c_half, hold};
              hold       <= '0;
              state      <= EMPTY;
            end else begin
              out_data_o <= {ins[15:0], hold};
              hold       <= ins[31:16];
            end
          end
          default: state <= EMPTY;
        endcase
      end else if (flush_go) begin
        out_data_o  <= {NOP_HALF, hold};
        out_valid_o <= 1'b1;
        hold        <= '0;
        state       <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_riscv_compressed_encoder.sv
// Bench for riscv_compressed_encoder: directed steps plus random
// instructions checked against an arithmetic RVC model and halfword queue.
module tb_riscv_compressed_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_instr_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        pending_o;
  logic        compressed_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  riscv_compressed_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_instr_i  (in_instr_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .pending_o   (pending_o),
    .compressed_o(compressed_o)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic bit p(input int r);
    return r >= 8 && r <= 15;
  endfunction

  // Reference compressor from the ISA rules, using integer ranges.
  function automatic void ref_enc(input  logic [31:0] w,
                                  output logic        ok,
                                  output logic [15:0] h);
    int op, f3, f7, rd, rs1, rs2, ii, is, iu;
    logic [31:0] u;
    logic [1:0] sl;
    op  = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    rd  = int'(w[11:7]);
    rs1 = int'(w[19:15]);
    rs2 = int'(w[24:20]);
    ii  = $signed(w[31:20]);
    is  = $signed({w[31:25], w[11:7]});
    iu  = $signed(w[31:12]);
    ok  = 1'b1;
    h   = 16'h0000;
    sl  = 2'b00;
    if (w[1:0] != 2'b11) ok = 1'b0;
    else if (op == 19 && f3 == 0 && rd == 0 &&
             rs1 == 0 && ii == 0)
      h = 16'h0001;
    else if (op == 19 && f3 == 0 && rd != 0 &&
             rs1 == 0 && ii >= -32 && ii <= 31) begin
      u = ii;
      h = {3'b010, u[5], w[11:7], u[4:0], 2'b01};
    end else if (op == 19 && f3 == 0 && rd != 0 &&
                 rs1 == rd && ii != 0 &&
                 ii >= -32 && ii <= 31) begin
      u = ii;
      h = {3'b000, u[5], w[11:7], u[4:0], 2'b01};
    end else if (op == 19 && f3 == 0 && rd == 2 &&
                 rs1 == 2 && ii != 0 && ii % 16 == 0 &&
                 ii >= -512 && ii <= 496) begin
      u = ii;
      h = {3'b011, u[9], 5'd2, u[4], u[6],
           u[8:7], u[5], 2'b01};
    end else if (op == 19 && f3 == 0 && p(rd) &&
                 rs1 == 2 && ii % 4 == 0 &&
                 ii >= 4 && ii <= 1020) begin
      u = ii;
      h = {3'b000, u[5:4], u[9:6], u[2], u[3],
           w[9:7], 2'b00};
    end else if (op == 55 && rd != 0 && rd != 2 &&
                 iu != 0 && iu >= -32 && iu <= 31) begin
      u = iu;
      h = {3'b011, u[5], w[11:7], u[4:0], 2'b01};
    end else if (op == 3 && f3 == 2 && p(rd) &&
                 p(rs1) && ii % 4 == 0 &&
                 ii >= 0 && ii <= 124) begin
      u = ii;
      h = {3'b010, u[5:3], w[17:15], u[2], u[6],
           w[9:7], 2'b00};
    end else if (op == 35 && f3 == 2 && p(rs2) &&
                 p(rs1) && is % 4 == 0 &&
                 is >= 0 && is <= 124) begin
      u = is;
      h = {3'b110, u[5:3], w[17:15], u[2], u[6],
           w[22:20], 2'b00};
    end else if (op == 3 && f3 == 2 && rd != 0 &&
                 rs1 == 2 && ii % 4 == 0 &&
                 ii >= 0 && ii <= 252) begin
      u = ii;
      h = {3'b010, u[5], w[11:7], u[4:2],
           u[7:6], 2'b10};
    end else if (op == 35 && f3 == 2 && rs1 == 2 &&
                 is % 4 == 0 && is >= 0 &&
                 is <= 252) begin
      u = is;
      h = {3'b110, u[5:2], u[7:6], w[24:20], 2'b10};
    end else if (op == 19 && f3 == 1 && f7 == 0 &&
                 rd != 0 && rs1 == rd && rs2 != 0)
      h = {4'b0000, w[11:7], w[24:20], 2'b10};
    else if (op == 19 && f3 == 5 &&
             (f7 == 0 || f7 == 32) && p(rd) &&
             rs1 == rd && rs2 != 0)
      h = {4'b1000, (f7 == 32) ? 2'b01 : 2'b00,
           w[9:7], w[24:20], 2'b01};
    else if (op == 19 && f3 == 7 && p(rd) &&
             rs1 == rd && ii >= -32 && ii <= 31) begin
      u = ii;
      h = {3'b100, u[5], 2'b10, w[9:7], u[4:0], 2'b01};
    end else if (op == 51 && f3 == 0 && f7 == 0 &&
                 rd != 0 && rs1 == 0 && rs2 != 0)
      h = {4'b1000, w[11:7], w[24:20], 2'b10};
    else if (op == 51 && f3 == 0 && f7 == 0 &&
             rd != 0 && rs1 == rd && rs2 != 0)
      h = {4'b1001, w[11:7], w[24:20], 2'b10};
    else if (op == 51 && p(rd) && rs1 == rd && p(rs2) &&
             ((f7 == 32 && f3 == 0) ||
              (f7 == 0 && (f3 == 4 || f3 == 6 ||
                           f3 == 7)))) begin
      sl = (f3 == 0) ? 2'b00 : (f3 == 4) ? 2'b01 :
           (f3 == 6) ? 2'b10 : 2'b11;
      h = {6'b100011, w[9:7], sl, w[22:20], 2'b01};
    end else if (w == 32'h00100073)
      h = 16'h9002;
`ifdef RVC_ENC_CTRL_EN
    else if (op == 103 && f3 == 0 && ii == 0 &&
             rs1 != 0 && rd <= 1)
      h = {3'b100, rd == 1, w[19:15], 5'd0, 2'b10};
    else if (op == 111 && rd <= 1 &&
             $signed({w[31], w[19:12], w[20],
                      w[30:21], 1'b0}) >= -2048 &&
             $signed({w[31], w[19:12], w[20],
                      w[30:21], 1'b0}) <= 2046) begin
      u = $signed({w[31], w[19:12], w[20],
                   w[30:21], 1'b0});
      h = {(rd == 1) ? 3'b001 : 3'b101, u[11], u[4],
           u[9:8], u[10], u[6], u[7], u[3:1],
           u[5], 2'b01};
    end else if (op == 99 && (f3 == 0 || f3 == 1) &&
                 rs2 == 0 && p(rs1) &&
                 $signed({w[31], w[7], w[30:25],
                          w[11:8], 1'b0}) >= -256 &&
                 $signed({w[31], w[7], w[30:25],
                          w[11:8], 1'b0}) <= 254) begin
      u = $signed({w[31], w[7], w[30:25],
                   w[11:8], 1'b0});
      h = {(f3 == 1) ? 3'b111 : 3'b110, u[8],
           u[4:3], w[17:15], u[7:6], u[2:1],
           u[5], 2'b01};
    end
`endif
    else ok = 1'b0;
  endfunction

  task automatic send(input logic [31:0] w,
                      input logic fl);
    logic ok;
    logic [15:0] h;
    logic [31:0] ew;
    bit have;
    int n;
    n = 0;
    ew = '0;
    ref_enc(w, ok, h);
    in_valid_i = 1'b1;
    in_instr_i = w;
    flush_i = fl;
    #1;
    check("compressed_o", 32'(compressed_o), 32'(ok));
    while (!in_ready_o && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_o", 32'(in_ready_o), 32'd1);
    if (ok) q.push_back(h);
    else begin
      q.push_back(w[15:0]);
      q.push_back(w[31:16]);
    end
    have = q.size() >= 2;
    if (have) begin
      ew = {q[1], q[0]};
      void'(q.pop_front());
      void'(q.pop_front());
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    check("out_valid_o", 32'(out_valid_o), 32'(have));
    if (have) check("out_data_o", out_data_o, ew);
    check("pending_o", 32'(pending_o),
          32'(q.size() != 0));
  endtask

  task automatic flush();
    bit have;
    logic [31:0] ew;
    ew = '0;
    in_valid_i = 1'b0;
    flush_i = 1'b1;
    have = q.size() == 1;
    if (have) begin
      ew = {16'h0001, q[0]};
      void'(q.pop_front());
    end
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush_valid", 32'(out_valid_o), 32'(have));
    if (have) check("flush_data", out_data_o, ew);
    check("flush_pending", 32'(pending_o), 32'd0);
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    @(posedge clk);
    #1;
    check("idle_valid", 32'(out_valid_o), 32'd0);
    check("idle_pending", 32'(pending_o),
          32'(q.size() != 0));
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd2;
      2, 3: return 5'(8 + $urandom_range(0, 7));
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic int pick_imm();
    int il[20] = '{-513, -512, -33, -32, -16, -1, 0,
                   1, 4, 16, 31, 32, 124, 128, 252,
                   256, 496, 512, 1020, 1024};
    if ($urandom_range(0, 3) == 0)
      return $signed(12'($urandom));
    return il[$urandom_range(0, 19)];
  endfunction

  function automatic logic [31:0] gen();
    logic [4:0] rd, rs1, rs2;
    logic [11:0] im;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [20:0] bj;
    logic [12:0] bb;
    logic [31:0] w;
    int jl[7] = '{-2048, -2050, 2046, 2048, -2, 100,
                  -1000};
    int bl[6] = '{-256, -258, 254, 256, -2, 8};
    rd  = pick_reg();
    rs1 = ($urandom_range(0, 1) == 1) ? rd : pick_reg();
    rs2 = pick_reg();
    im  = 12'(pick_imm());
    f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    f3  = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 12))
      0, 1: return {im, rs1, 3'b000, rd, 7'h13};
      2: return {im, rs1, 3'b111, rd, 7'h13};
      3: return {f7, rs2, rs1,
                 ($urandom_range(0, 1) == 1) ?
                 3'b001 : 3'b101, rd, 7'h13};
      4: return {{8{im[11]}}, im, rd, 7'h37};
      5: return {im, rs1, 3'b010, rd, 7'h03};
      6: return {im[11:5], rs2, rs1, 3'b010,
                 im[4:0], 7'h23};
      7: return {f7, rs2, rs1, f3, rd, 7'h33};
      8: return ($urandom_range(0, 1) == 1) ?
                32'h00100073 : 32'h00000013;
      9: return $urandom;
      10: begin
        w = $urandom;
        w[1:0] = 2'($urandom_range(0, 2));
        return w;
      end
      11: return {($urandom_range(0, 2) == 0) ?
                  im : 12'h000, rs1, 3'b000,
                  5'($urandom_range(0, 2)), 7'h67};
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          bj = 21'(jl[$urandom_range(0, 6)]);
          return {bj[20], bj[10:1], bj[11],
                  bj[19:12],
                  5'($urandom_range(0, 2)), 7'h6F};
        end
        bb = 13'(bl[$urandom_range(0, 5)]);
        return {bb[12], bb[10:5],
                ($urandom_range(0, 3) == 0) ?
                rs2 : 5'd0,
                5'(8 + $urandom_range(0, 8)),
                3'($urandom_range(0, 2)),
                bb[4:1], bb[11], 7'h63};
      end
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    in_valid_i = 1'b0;
    in_instr_i = '0;
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_data", out_data_o, 32'd0);
    check("rst_pending", 32'(pending_o), 32'd0);
    check("rst_ready", 32'(in_ready_o), 32'd1);

    send(32'h00140413, 1'b0);
    check("pair_pend", 32'(pending_o), 32'd1);
    send(32'h00500513, 1'b0);
    check("pair_word", out_data_o, 32'h45150405);
    check("pair_pend0", 32'(pending_o), 32'd0);

    send(32'h003100B3, 1'b0);
    check("pass_word", out_data_o, 32'h003100B3);

    send(32'h00140413, 1'b0);
    send(32'h003100B3, 1'b0);
    check("split_word", out_data_o, 32'h00B30405);
    check("split_pend", 32'(pending_o), 32'd1);
    flush();
    check("split_flush", out_data_o, 32'h00010031);

    flush();
    idle();

    out_ready_i = 1'b0;
    send(32'h00140413, 1'b0);
    send(32'h00500513, 1'b0);
    in_valid_i = 1'b1;
    in_instr_i = 32'h003100B3;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", 32'(in_ready_o), 32'd0);
      check("bp_valid", 32'(out_valid_o), 32'd1);
      check("bp_data", out_data_o, 32'h45150405);
      @(posedge clk);
      #1;
    end
    out_ready_i = 1'b1;
    #1;
    check("bp_release", 32'(in_ready_o), 32'd1);
    send(32'h003100B3, 1'b0);
    check("bp_next", out_data_o, 32'h003100B3);

    send(32'h00140413, 1'b0);
    send(32'h003100B3, 1'b0);
    check("hr_valid", 32'(out_valid_o), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    check("hr_valid0", 32'(out_valid_o), 32'd0);
    check("hr_data0", out_data_o, 32'd0);
    check("hr_pend0", 32'(pending_o), 32'd0);
    send(32'h00140413, 1'b0);
    flush();
    check("hr_flush", out_data_o, 32'h00010405);

    send(32'h00140413, 1'b0);
    send(32'h00500513, 1'b1);
    check("fv_word", out_data_o, 32'h45150405);
    send(32'h00140413, 1'b1);
    check("fv_pend", 32'(pending_o), 32'd1);
    flush();

`ifdef RVC_ENC_CTRL_EN
    send(32'h00008067, 1'b0);
    check("jr_pend", 32'(pending_o), 32'd1);
    flush();
    check("jr_word", out_data_o, 32'h00018082);
`else
    send(32'h00008067, 1'b0);
    check("jr_word", out_data_o, 32'h00008067);
`endif

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: flush();
        1: idle();
        default: send(gen(), 1'b0);
      endcase
    end
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
